pc_gen: RTL and testbench

Parametrised program-counter generation unit for the fetch stage. Holds the architectural fetch PC and selects the next fetch address each cycle. Sources, in priority order: reset vector, trap vector, mispredict correction, stall hold, branch prediction, sequential PC+4. Supplies the PC, a valid flag, a redirect epoch and a branch-prediction hint to the instruction-memory / fetch pipeline register.

---
 rtl/pc_gen.sv | 141 ++++++++++++++
 tb/tb_pc_gen.sv | 174 +++++++++++++++++
 2 files changed

// File: rtl/pc_gen.sv
// Fetch-stage program counter: reset/boot sequencing, redirect priority and optional BTB prediction.
// Optional feature macro: PC_GEN_BTB_EN (direct-mapped BTB with 2-bit counters).
module pc_gen #(
  parameter int               XLEN         = 32,
  parameter logic [XLEN-1:0]  RESET_VECTOR = '0,
  parameter int               BTB_ENTRIES  = 16,
  parameter int               EPOCH_W      = 2
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               stall_i,
  input  logic               mispredict_i,
  input  logic [XLEN-1:0]    mispredict_target_i,
  input  logic               trap_i,
  input  logic [XLEN-1:0]    trap_vector_i,
  input  logic               btb_update_i,
  input  logic [XLEN-1:0]    btb_update_pc_i,
  input  logic [XLEN-1:0]    btb_update_target_i,
  input  logic               btb_update_taken_i,
  output logic [XLEN-1:0]    pc_o,
  output logic               pc_valid_o,
  output logic               pred_taken_o,
  output logic [XLEN-1:0]    pred_target_o,
  output logic [EPOCH_W-1:0] epoch_o,
  output logic               misaligned_o
);

  typedef enum logic [1:0] {RESET, BOOT, RUN} state_t;

  state_t state;

`ifdef PC_GEN_BTB_EN
  localparam int IW = $clog2(BTB_ENTRIES);
  localparam int TW = XLEN - IW - 2;

  logic [BTB_ENTRIES-1:0] btb_valid;
  logic [TW-1:0]          btb_tag    [BTB_ENTRIES];
  logic [XLEN-1:0]        btb_target [BTB_ENTRIES];
  logic [1:0]             btb_ctr    [BTB_ENTRIES];

  logic [IW-1:0] look_idx;
  logic [TW-1:0] look_tag;
  logic [IW-1:0] upd_idx;
  logic [TW-1:0] upd_tag;
  logic          upd_hit;
  logic [3:0]    unused_low_bits;

  assign look_idx        = pc_o[IW+1:2];
  assign look_tag        = pc_o[XLEN-1:IW+2];
  assign upd_idx         = btb_update_pc_i[IW+1:2];
  assign upd_tag         = btb_update_pc_i[XLEN-1:IW+2];
  assign upd_hit         = btb_valid[upd_idx] && (btb_tag[upd_idx] == upd_tag);
  assign unused_low_bits = {pc_o[1:0], btb_update_pc_i[1:0]};

  // Lookup reads the array directly, so a same-cycle update is only visible from the next cycle.
  assign pred_taken_o  = btb_valid[look_idx] && (btb_tag[look_idx] == look_tag) && btb_ctr[look_idx][1];
  assign pred_target_o = btb_target[look_idx];

  always_ff @(posedge clk) begin
    if (rst) begin
      btb_valid <= '0;
    end else if (btb_update_i && !upd_hit && btb_update_taken_i) begin
      btb_valid[upd_idx] <= 1'b1;
    end
  end

  // Payload needs no reset; a cleared valid bit masks whatever it holds.
  always_ff @(posedge clk) begin
    if (!rst && btb_update_i) begin
      if (upd_hit) begin
        if (btb_update_taken_i) begin
          btb_target[upd_idx] <= btb_update_target_i;
          if (btb_ctr[upd_idx] != 2'd3) btb_ctr[upd_idx] <= btb_ctr[upd_idx] + 2'd1;
        end else if (btb_ctr[upd_idx] != 2'd0) begin
          btb_ctr[upd_idx] <= btb_ctr[upd_idx] - 2'd1;
        end
      end else if (btb_update_taken_i) begin
        btb_tag[upd_idx]    <= upd_tag;
        btb_target[upd_idx] <= btb_update_target_i;
        btb_ctr[upd_idx]    <= 2'd2;
      end
    end
  end
`else
  logic unused_btb;

  assign pred_taken_o  = 1'b0;
  assign pred_target_o = '0;
  assign unused_btb    = ^{btb_update_i, btb_update_pc_i, btb_update_target_i,
                           btb_update_taken_i, 9'(BTB_ENTRIES)};
`endif

  // BOOT presents RESET_VECTOR without a valid fetch, then RUN resumes from the following word.
  always_ff @(posedge clk) begin
    if (rst) begin
      state        <= RESET;
      pc_o         <= RESET_VECTOR;
      pc_valid_o   <= 1'b0;
      epoch_o      <= '0;
      misaligned_o <= 1'b0;
    end else begin
      misaligned_o <= 1'b0;
      case (state)
        RESET: begin
          state      <= BOOT;
          pc_o       <= RESET_VECTOR;
          pc_valid_o <= 1'b0;
        end
        BOOT: begin
          state      <= RUN;
          pc_o       <= RESET_VECTOR + XLEN'(4);
          pc_valid_o <= 1'b1;
        end
        RUN: begin
          pc_valid_o <= 1'b1;
          if (trap_i) begin
            pc_o         <= {trap_vector_i[XLEN-1:2], 2'b00};
            misaligned_o <= |trap_vector_i[1:0];
            epoch_o      <= epoch_o + EPOCH_W'(1);
          end else if (mispredict_i) begin
            pc_o         <= {mispredict_target_i[XLEN-1:2], 2'b00};
            misaligned_o <= |mispredict_target_i[1:0];
            epoch_o      <= epoch_o + EPOCH_W'(1);
          end else if (stall_i) begin
            pc_o <= pc_o;
          end else if (pred_taken_o) begin
            pc_o <= pred_target_o;
          end else begin
            pc_o <= pc_o + XLEN'(4);
          end
        end
        default: begin
          state      <= RESET;
          pc_o       <= RESET_VECTOR;
          pc_valid_o <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_pc_gen.sv
// Directed self-checking bench for pc_gen with RESET_VECTOR=0x100; BTB checks run when PC_GEN_BTB_EN is defined.
module tb_pc_gen;

  logic        clk = 1'b0;
  logic        rst;
  logic        stall_i;
  logic        mispredict_i;
  logic [31:0] mispredict_target_i;
  logic        trap_i;
  logic [31:0] trap_vector_i;
  logic        btb_update_i;
  logic [31:0] btb_update_pc_i;
  logic [31:0] btb_update_target_i;
  logic        btb_update_taken_i;
  logic [31:0] pc_o;
  logic        pc_valid_o;
  logic        pred_taken_o;
  logic [31:0] pred_target_o;
  logic [1:0]  epoch_o;
  logic        misaligned_o;

  int checks   = 0;
  int failures = 0;

  pc_gen #(
    .XLEN(32), .RESET_VECTOR(32'h100), .BTB_ENTRIES(16), .EPOCH_W(2)
  ) dut (
    .clk(clk), .rst(rst), .stall_i(stall_i),
    .mispredict_i(mispredict_i), .mispredict_target_i(mispredict_target_i),
    .trap_i(trap_i), .trap_vector_i(trap_vector_i),
    .btb_update_i(btb_update_i), .btb_update_pc_i(btb_update_pc_i),
    .btb_update_target_i(btb_update_target_i), .btb_update_taken_i(btb_update_taken_i),
    .pc_o(pc_o), .pc_valid_o(pc_valid_o), .pred_taken_o(pred_taken_o),
    .pred_target_o(pred_target_o), .epoch_o(epoch_o), .misaligned_o(misaligned_o)
  );

  always #5 clk = ~clk;

  task automatic checkOutput(input string tag, input logic [31:0] actual, input logic [31:0] expected);
    checks++;
    if (actual !== expected) begin
      failures++;
      $display("[TB] FAIL %s: got 0x%08h expected 0x%08h", tag, actual, expected);
    end
  endtask

  // Drives one cycle of inputs, clocks once, and leaves time 1 unit past the edge for sampling.
  task automatic applyStimulus(input logic r, input logic st, input logic mp, input logic [31:0] mpt,
                               input logic tr, input logic [31:0] tv, input logic bu,
                               input logic [31:0] bpc, input logic [31:0] btgt, input logic btk);
    rst = r; stall_i = st; mispredict_i = mp; mispredict_target_i = mpt;
    trap_i = tr; trap_vector_i = tv; btb_update_i = bu; btb_update_pc_i = bpc;
    btb_update_target_i = btgt; btb_update_taken_i = btk;
    @(posedge clk);
    #1;
  endtask

  task automatic idle();
    applyStimulus(0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
  endtask

  task automatic redirect(input logic [31:0] target);
    applyStimulus(0, 0, 1, target, 0, 0, 0, 0, 0, 0);
  endtask

  task automatic btbUpdate(input logic [31:0] bpc, input logic [31:0] btgt, input logic btk);
    applyStimulus(0, 0, 0, 0, 0, 0, 1, bpc, btgt, btk);
  endtask

  initial begin
    applyStimulus(1, 0, 0, 0, 0, 0, 0, 0, 0, 0);
    applyStimulus(1, 0, 0, 0, 0, 0, 0, 0, 0, 0);
    checkOutput("reset_pc", pc_o, 32'h100);
    checkOutput("reset_valid", 32'(pc_valid_o), 0);
    checkOutput("reset_epoch", 32'(epoch_o), 0);
    checkOutput("reset_misaligned", 32'(misaligned_o), 0);
    checkOutput("reset_pred", 32'(pred_taken_o), 0);

    // Boot: redirects and stall are ignored while BOOT holds the reset vector.
    applyStimulus(0, 1, 1, 32'h700, 1, 32'h800, 0, 0, 0, 0);
    checkOutput("boot_pc", pc_o, 32'h100);
    checkOutput("boot_valid", 32'(pc_valid_o), 0);
    checkOutput("boot_epoch", 32'(epoch_o), 0);
    idle();
    checkOutput("run_pc0", pc_o, 32'h104);
    checkOutput("run_valid", 32'(pc_valid_o), 1);
    idle();
    checkOutput("run_pc1", pc_o, 32'h108);

    redirect(32'h200);
    checkOutput("redir_pc", pc_o, 32'h200);
    checkOutput("redir_epoch", 32'(epoch_o), 1);
    applyStimulus(0, 1, 0, 0, 0, 0, 0, 0, 0, 0);
    checkOutput("stall1_pc", pc_o, 32'h200);
    applyStimulus(0, 1, 0, 0, 0, 0, 0, 0, 0, 0);
    checkOutput("stall2_pc", pc_o, 32'h200);
    applyStimulus(0, 1, 1, 32'h400, 0, 0, 0, 0, 0, 0);
    checkOutput("stall_mp_pc", pc_o, 32'h400);
    checkOutput("stall_mp_epoch", 32'(epoch_o), 2);

    applyStimulus(0, 0, 1, 32'h500, 1, 32'h80, 0, 0, 0, 0);
    checkOutput("prio_pc", pc_o, 32'h80);
    checkOutput("prio_epoch", 32'(epoch_o), 3);
    checkOutput("prio_misaligned", 32'(misaligned_o), 0);
    idle();
    checkOutput("prio_next_pc", pc_o, 32'h84);

    redirect(32'h503);
    checkOutput("align_pc", pc_o, 32'h500);
    checkOutput("align_misaligned", 32'(misaligned_o), 1);
    checkOutput("align_epoch_wrap", 32'(epoch_o), 0);
    idle();
    checkOutput("align_next_pc", pc_o, 32'h504);
    checkOutput("align_pulse_end", 32'(misaligned_o), 0);

    applyStimulus(0, 0, 0, 0, 1, 32'h82, 0, 0, 0, 0);
    checkOutput("trap_align_pc", pc_o, 32'h80);
    checkOutput("trap_misaligned", 32'(misaligned_o), 1);

    redirect(32'hFFFF_FFFC);
    checkOutput("wrap_top_pc", pc_o, 32'hFFFF_FFFC);
    checkOutput("wrap_top_epoch", 32'(epoch_o), 2);
    idle();
    checkOutput("wrap_pc", pc_o, 32'h0);

`ifdef PC_GEN_BTB_EN
    applyStimulus(0, 0, 1, 32'h3C, 0, 0, 1, 32'h40, 32'h90, 1);
    checkOutput("btb_pre_pc", pc_o, 32'h3C);
    checkOutput("btb_pre_pred", 32'(pred_taken_o), 0);
    idle();
    checkOutput("btb_hit_pc", pc_o, 32'h40);
    checkOutput("btb_hit_pred", 32'(pred_taken_o), 1);
    checkOutput("btb_hit_target", pred_target_o, 32'h90);
    idle();
    checkOutput("btb_taken_pc", pc_o, 32'h90);
    btbUpdate(32'h40, 32'h90, 0);
    btbUpdate(32'h40, 32'h90, 0);
    redirect(32'h40);
    checkOutput("btb_weak_pred", 32'(pred_taken_o), 0);
    idle();
    checkOutput("btb_fallback_pc", pc_o, 32'h44);
    btbUpdate(32'h40, 32'h90, 1);
    btbUpdate(32'h40, 32'h90, 1);
    redirect(32'h40);
    checkOutput("btb_retrain_pred", 32'(pred_taken_o), 1);
`else
    applyStimulus(0, 0, 1, 32'h40, 0, 0, 1, 32'h40, 32'h90, 1);
    checkOutput("nobtb_pc", pc_o, 32'h40);
    idle();
    checkOutput("nobtb_pred", 32'(pred_taken_o), 0);
    checkOutput("nobtb_seq_pc", pc_o, 32'h44);
`endif

    redirect(32'h300);
    checkOutput("midrun_pc", pc_o, 32'h300);
    applyStimulus(1, 0, 1, 32'h600, 1, 32'h700, 0, 0, 0, 0);
    checkOutput("midrst_pc", pc_o, 32'h100);
    checkOutput("midrst_epoch", 32'(epoch_o), 0);
    checkOutput("midrst_valid", 32'(pc_valid_o), 0);
    idle();
    checkOutput("midrst_boot_pc", pc_o, 32'h100);
    idle();
    checkOutput("midrst_run_pc", pc_o, 32'h104);
    redirect(32'h40);
    checkOutput("midrst_btb_pc", pc_o, 32'h40);
    checkOutput("midrst_btb_miss", 32'(pred_taken_o), 0);
    idle();
    checkOutput("midrst_seq_pc", pc_o, 32'h44);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
